dmem_responder: RTL and testbench
=================================

# dmem_responder

Memory-side responder for the core's data-memory port: accepts load/store requests over a valid/ready handshake, performs byte/half/word access into an internal word array, and returns a registered response after a programmable wait. It sits between the core's load/store path and backing storage. It adds multi-cycle latency, byte-lane handling and error signalling that the combinational data memory lacks.

## Interface
- DEPTH, 1024: number of 32-bit words stored.
- BASE_ADDR, 32'h0000_0000: byte address of word 0.
- WAIT_CYCLES, 2: cycles spent in BUSY before a response (0 allowed).
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset (asserted at 0).
- req_valid  input  1  request present.
- req_ready  output  1  responder can accept a request.
- req_we  input  1  1 = store, 0 = load.
- req_funct3  input  3  RV32I width code: 000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU.
- req_addr  input  32  byte address.
- req_wdata  input  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- rsp_valid  output  1  response present.
- rsp_ready  input  1  requester accepts response.
- rsp_rdata  output  32  load data, sign/zero-extended; 0 for stores and errors.
- rsp_err  output  1  access faulted (range or alignment).

## Operation
- FSM states: IDLE, BUSY, RESP.
- IDLE: req_ready=1. On req_valid&&req_ready, latch we/funct3/addr/wdata. Go to BUSY with counter=WAIT_CYCLES-1, or to RESP directly if WAIT_CYCLES=0.
- BUSY: req_ready=0. Counter decrements each cycle. At counter=0 the access executes and the state goes to RESP.
- Access: offset=addr-BASE_ADDR, word index=offset[log2(DEPTH)+1:2], lane=offset[1:0].
- Out of range when addr<BASE_ADDR or offset>=4*DEPTH. Result: rsp_err=1, no write, rsp_rdata=0.
- Invalid funct3 (011, 110, 111; or 100/101 with we=1): rsp_err=1, no write.
- Store writes only the addressed lanes: SB writes 1 byte, SH 2 bytes, SW 4 bytes. Other bytes of the word are unchanged.
- Load: select lane(s), then sign-extend (LB/LH) or zero-extend (LBU/LHU/LW).
- RESP: rsp_valid=1 and rsp_rdata/rsp_err are stable until rsp_ready. On rsp_valid&&rsp_ready, go to IDLE. No new request is accepted in the same cycle.
- Memory contents are not reset. Their initial value is undefined to the bench.

## Timing
- Reset values: state=IDLE, req_ready=0 while reset=0, then 1; rsp_valid=0, rsp_rdata=0, rsp_err=0, counter=0.
- Latency from the accept edge to rsp_valid high is WAIT_CYCLES+1 cycles. With WAIT_CYCLES=0, rsp_valid rises on the cycle after accept.
- Store commit happens on the clock edge that enters RESP. A load issued after that response completes observes the new data.
- Throughput is at most one transaction per WAIT_CYCLES+2 cycles (accept, wait, response, return to IDLE).
- Reset asserted in BUSY: the store is dropped (not committed) and the response is lost. Reset asserted in RESP: the store is already committed and the response is lost.
- req_* inputs are ignored outside IDLE. rsp_ready is ignored outside RESP.

## Configuration
- DMEM_MISALIGN_TRAP_EN defined: an LH/LHU/SH with lane[0]=1, or an LW/SW with lane!=0, gives rsp_err=1, no write, rsp_rdata=0.
- DMEM_MISALIGN_TRAP_EN undefined: the low address bits are forced aligned before access (half: lane[0]=0; word: lane=0), and no error is raised.

## Structure
- Package dmem_pkg holds:
  - funct3 width-code constants (F3_B, F3_H, F3_W, F3_BU, F3_HU);
  - the FSM state enum (IDLE, BUSY, RESP);
  - a function deriving the byte-enable mask from funct3 and lane.
- Sub-module dmem_lane_align is combinational. It takes funct3, lane, the stored word and wdata. It produces the byte-enable mask, the shifted write word, the extended read data and the misalign flag.
- The top level holds the FSM, counter, request latches, storage array and response registers.

## Test plan
- Reset and idle: with reset=0 for 3 cycles, rsp_valid=0, rsp_rdata=0, req_ready=0. After release, req_ready=1 on the next cycle.
- SW then LW: SW addr=0x10 data=0xDEADBEEF (WAIT_CYCLES=2), then LW addr=0x10. Response arrives 3 cycles after accept with rsp_rdata=0xDEADBEEF, rsp_err=0.
- Byte merge and extension: after the word above, SB addr=0x11 data=0x80. Then LW 0x10 returns 0xDEAD80EF, LB 0x11 returns 0xFFFFFF80, LBU 0x11 returns 0x00000080.
- Backpressure: hold rsp_ready=0 for 5 cycles. rsp_valid and rsp_rdata stay stable, and req_ready stays 0 with req_valid=1 asserted.
- Errors: LW at BASE_ADDR+4*DEPTH gives rsp_err=1, rsp_rdata=0. With DMEM_MISALIGN_TRAP_EN defined, SW at 0x12 gives rsp_err=1 and word 0x10 is unchanged. With the macro undefined, the same SW writes word 0x10 with rsp_err=0.
- Reset mid-BUSY: SW 0x20 data=0x12345678, then assert reset one cycle after accept. After release, LW 0x20 does not return 0x12345678 (prior contents are preloaded as 0x0 by the bench).

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: width codes, FSM states
// and the byte-enable helper.
package dmem_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

   function automatic logic [3:0] byte_en(input logic [2:0] funct3, input logic [1:0] lane);
      logic [3:0] base;
      case (funct3)
         F3_B, F3_BU: base = 4'b0001;
         F3_H, F3_HU: base = 4'b0011;
         F3_W:        base = 4'b1111;
         default:     base = 4'b0000;
      endcase
      return base << lane;
   endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational byte-lane steering: write-data shift, byte enables,
// load extraction with sign/zero extension, and misalignment detection.
module dmem_lane_align
   import dmem_pkg::*;
(
   input  logic [2:0]  funct3,
   input  logic [1:0]  lane,
   input  logic [31:0] word,
   input  logic [31:0] wdata,
   output logic [3:0]  be,
   output logic [31:0] wword,
   output logic [31:0] rdata,
   output logic        misalign
);

   logic [31:0] shifted;

   always_comb begin
      be       = byte_en(funct3, lane);
      wword    = wdata << {lane, 3'b000};
      shifted  = word >> {lane, 3'b000};
      rdata    = '0;
      misalign = 1'b0;
      case (funct3)
         F3_B:  rdata = {{24{shifted[7]}}, shifted[7:0]};
         F3_BU: rdata = {24'h0, shifted[7:0]};
         F3_H: begin
            rdata    = {{16{shifted[15]}}, shifted[15:0]};
            misalign = lane[0];
         end
         F3_HU: begin
            rdata    = {16'h0, shifted[15:0]};
            misalign = lane[0];
         end
         F3_W: begin
            rdata    = shifted;
            misalign = (lane != 2'b00);
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder with valid/ready request/response and programmable wait.
// DMEM_MISALIGN_TRAP_EN: trap misaligned half/word accesses instead of aligning them.
module dmem_responder
   import dmem_pkg::*;
#(
   parameter int          DEPTH       = 1024,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
   parameter int          WAIT_CYCLES = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err
);

   localparam int          AW   = $clog2(DEPTH);
   localparam int          CW   = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
   localparam logic [32:0] SPAN = 33'(4 * DEPTH);

   state_t        state, state_next;
   logic [CW-1:0] cnt, cnt_next;
   logic          armed, exec, accept;

   logic          we_q;
   logic [2:0]    f3_q;
   logic [31:0]   addr_q, wdata_q;

   logic [31:0]   mem [DEPTH];

   logic          a_we, oor, bad_f3, misalign, err;
   logic [2:0]    a_f3;
   logic [31:0]   a_addr, a_wdata, offset, word, wword, ld_data;
   logic [AW-1:0] idx;
   logic [1:0]    lane, lane_eff;
   logic [3:0]    be;

   assign accept = req_valid && req_ready;

   // With no wait the access executes on the accept edge, so it must see the live request.
   assign a_we    = (state == IDLE) ? req_we     : we_q;
   assign a_f3    = (state == IDLE) ? req_funct3 : f3_q;
   assign a_addr  = (state == IDLE) ? req_addr   : addr_q;
   assign a_wdata = (state == IDLE) ? req_wdata  : wdata_q;

   assign offset = a_addr - BASE_ADDR;
   assign oor    = (a_addr < BASE_ADDR) || ({1'b0, offset} >= SPAN);
   assign idx    = offset[AW+1:2];
   assign lane   = offset[1:0];
   assign bad_f3 = (a_f3 == 3'b011) || (a_f3 == 3'b110) || (a_f3 == 3'b111) ||
                   (a_we && (a_f3 == F3_BU || a_f3 == F3_HU));
   assign word   = mem[idx];
   assign err    = oor || bad_f3 || misalign;

`ifdef DMEM_MISALIGN_TRAP_EN
   assign lane_eff = lane;
`else
   always_comb begin
      lane_eff = lane;
      if (a_f3 == F3_H || a_f3 == F3_HU) lane_eff[0] = 1'b0;
      else if (a_f3 == F3_W)             lane_eff    = 2'b00;
   end
`endif

   dmem_lane_align u_align (
      .funct3   (a_f3),
      .lane     (lane_eff),
      .word     (word),
      .wdata    (a_wdata),
      .be       (be),
      .wword    (wword),
      .rdata    (ld_data),
      .misalign (misalign)
   );

   always_comb begin
      state_next = state;
      cnt_next   = cnt;
      req_ready  = 1'b0;
      rsp_valid  = 1'b0;
      exec       = 1'b0;
      case (state)
         IDLE: begin
            req_ready = armed;
            if (req_valid && armed) begin
               if (WAIT_CYCLES == 0) begin
                  state_next = RESP;
                  exec       = 1'b1;
               end else begin
                  state_next = BUSY;
                  cnt_next   = CW'(WAIT_CYCLES - 1);
               end
            end
         end
         BUSY: begin
            if (cnt == '0) begin
               state_next = RESP;
               exec       = 1'b1;
            end else begin
               cnt_next = cnt - CW'(1);
            end
         end
         RESP: begin
            rsp_valid = 1'b1;
            if (rsp_ready) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         cnt       <= '0;
         armed     <= 1'b0;
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
      end else begin
         state <= state_next;
         cnt   <= cnt_next;
         armed <= 1'b1;
         if (exec) begin
            rsp_err   <= err;
            rsp_rdata <= (err || a_we) ? 32'h0 : ld_data;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (accept) begin
         we_q    <= req_we;
         f3_q    <= req_funct3;
         addr_q  <= req_addr;
         wdata_q <= req_wdata;
      end
   end

   // Storage is not reset; a reset during BUSY forces IDLE so exec never fires.
   always_ff @(posedge clk) begin
      if (exec && a_we && !err) begin
         for (int b = 0; b < 4; b++) begin
            if (be[b]) mem[idx][8*b +: 8] <= wword[8*b +: 8];
         end
      end
   end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed scenarios plus randomized
// traffic against a byte-addressed reference model.
module tb_dmem_responder;

   localparam int          DEPTH = 1024;
   localparam logic [31:0] BASE  = 32'h0000_0000;
   localparam int          WAIT  = 2;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_we = 1'b0;
   logic [2:0]  req_funct3 = 3'b000;
   logic [31:0] req_addr = 32'h0;
   logic [31:0] req_wdata = 32'h0;
   logic        rsp_ready = 1'b0;
   logic        req_ready, rsp_valid, rsp_err;
   logic [31:0] rsp_rdata;

   int passed = 0;
   int total  = 0;

   logic [7:0] mdl [logic [31:0]];

   always #5 clk = ~clk;

   dmem_responder #(.DEPTH(DEPTH), .BASE_ADDR(BASE), .WAIT_CYCLES(WAIT)) dut (
      .clk        (clk),
      .reset      (reset),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_we     (req_we),
      .req_funct3 (req_funct3),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_rdata  (rsp_rdata),
      .rsp_err    (rsp_err)
   );

   // Reference: memory as a map of bytes; loads with unwritten bytes are "unknown".
   function automatic void model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                 input logic [31:0] wdata, output logic [31:0] rd,
                                 output logic er, output bit known);
      int unsigned size;
      logic [31:0] a, v;
      rd = 32'h0; er = 1'b0; known = 1'b1;
      case (f3)
         3'b000, 3'b100: size = 1;
         3'b001, 3'b101: size = 2;
         3'b010:         size = 4;
         default:        size = 0;
      endcase
      if (size == 0 || (we && f3[2])) er = 1'b1;
      if (addr < BASE || (addr - BASE) >= 32'(4 * DEPTH)) er = 1'b1;
`ifdef DMEM_MISALIGN_TRAP_EN
      if (size != 0 && ((addr - BASE) % size) != 0) er = 1'b1;
`endif
      if (er) return;
      a = BASE + ((addr - BASE) / size) * size;
      if (we) begin
         for (int i = 0; i < int'(size); i++) mdl[a + 32'(i)] = wdata[8*i +: 8];
         return;
      end
      v = 32'h0;
      for (int i = 0; i < int'(size); i++) begin
         if (!mdl.exists(a + 32'(i))) known = 1'b0;
         else v = v | (32'(mdl[a + 32'(i)]) << (8 * i));
      end
      if (f3 == 3'b000 && v[7])  v = v | 32'hFFFF_FF00;
      if (f3 == 3'b001 && v[15]) v = v | 32'hFFFF_0000;
      rd = v;
   endfunction

   task automatic txn(input logic we, input logic [2:0] f3, input logic [31:0] a,
                      input logic [31:0] d, input int hold,
                      output logic [31:0] rd, output logic er, output int lat);
      int n;
      @(negedge clk);
      n = 0;
      while (!req_ready && n < 20) begin @(negedge clk); n++; end
      req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = d;
      @(posedge clk); #1;
      req_valid  = 1'b0;
      req_we     = 1'($urandom);
      req_funct3 = 3'($urandom);
      req_addr   = $urandom;
      req_wdata  = $urandom;
      lat = 1;
      while (!rsp_valid && lat < 40) begin @(posedge clk); #1; lat++; end
      rd = rsp_rdata; er = rsp_err;
      repeat (hold) @(posedge clk);
      #1 rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
   endtask

   task automatic test_reset;
      reset = 1'b0;
      req_valid = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         total++; if (rsp_valid !== 1'b0) $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); else passed++;
         total++; if (rsp_rdata !== 32'h0) $display("FAIL reset_rsp_rdata got=%h exp=0", rsp_rdata); else passed++;
         total++; if (rsp_err !== 1'b0) $display("FAIL reset_rsp_err got=%b exp=0", rsp_err); else passed++;
         total++; if (req_ready !== 1'b0) $display("FAIL reset_req_ready got=%b exp=0", req_ready); else passed++;
      end
      req_valid = 1'b0;
      reset = 1'b1;
      @(posedge clk); #1;
      total++; if (req_ready !== 1'b1) $display("FAIL idle_req_ready got=%b exp=1", req_ready); else passed++;
      total++; if (rsp_valid !== 1'b0) $display("FAIL idle_rsp_valid got=%b exp=0", rsp_valid); else passed++;
   endtask

   task automatic test_sw_lw;
      logic [31:0] rd, mrd; logic er, mer; bit kn; int lat;
      model(1'b1, 3'b010, 32'h10, 32'hDEAD_BEEF, mrd, mer, kn);
      txn(1'b1, 3'b010, 32'h10, 32'hDEAD_BEEF, 0, rd, er, lat);
      total++; if (er !== 1'b0) $display("FAIL sw_err got=%b exp=0", er); else passed++;
      total++; if (rd !== 32'h0) $display("FAIL sw_rdata got=%h exp=0", rd); else passed++;
      total++; if (lat != WAIT + 1) $display("FAIL sw_latency got=%0d exp=%0d", lat, WAIT + 1); else passed++;
      model(1'b0, 3'b010, 32'h10, 32'h0, mrd, mer, kn);
      txn(1'b0, 3'b010, 32'h10, 32'h0, 0, rd, er, lat);
      total++; if (rd !== 32'hDEAD_BEEF) $display("FAIL lw_rdata got=%h exp=deadbeef", rd); else passed++;
      total++; if (er !== 1'b0) $display("FAIL lw_err got=%b exp=0", er); else passed++;
      total++; if (lat != WAIT + 1) $display("FAIL lw_latency got=%0d exp=%0d", lat, WAIT + 1); else passed++;
   endtask

   task automatic test_byte_merge;
      logic [31:0] rd, mrd; logic er, mer; bit kn; int lat;
      logic [2:0]  f3s [5] = '{3'b010, 3'b000, 3'b100, 3'b001, 3'b101};
      logic [31:0] ads [5] = '{32'h10, 32'h11, 32'h11, 32'h12, 32'h10};
      logic [31:0] exs [5] = '{32'hDEAD_80EF, 32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_DEAD, 32'h0000_80EF};
      model(1'b1, 3'b000, 32'h11, 32'h80, mrd, mer, kn);
      txn(1'b1, 3'b000, 32'h11, 32'h80, 1, rd, er, lat);
      total++; if (er !== 1'b0) $display("FAIL sb_err got=%b exp=0", er); else passed++;
      for (int i = 0; i < 5; i++) begin
         model(1'b0, f3s[i], ads[i], 32'h0, mrd, mer, kn);
         txn(1'b0, f3s[i], ads[i], 32'h0, i % 2, rd, er, lat);
         total++;
         if (rd !== exs[i] || er !== 1'b0)
            $display("FAIL merge_load%0d f3=%b addr=%h got=%h/%b exp=%h/0", i, f3s[i], ads[i], rd, er, exs[i]);
         else passed++;
      end
   endtask

   task automatic test_backpressure;
      logic [31:0] rd, mrd; logic er, mer; bit kn; int lat, n;
      @(negedge clk);
      n = 0;
      while (!req_ready && n < 20) begin @(negedge clk); n++; end
      req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h10;
      @(posedge clk); #1;
      req_valid = 1'b0;
      n = 0;
      while (!rsp_valid && n < 40) begin @(posedge clk); #1; n++; end
      req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h10; req_wdata = 32'h0;
      for (int c = 0; c < 5; c++) begin
         total++;
         if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hDEAD_80EF || req_ready !== 1'b0)
            $display("FAIL backpressure_c%0d got valid=%b rdata=%h ready=%b exp 1/dead80ef/0",
                     c, rsp_valid, rsp_rdata, req_ready);
         else passed++;
         @(posedge clk); #1;
      end
      req_valid = 1'b0;
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      total++; if (rsp_valid !== 1'b0) $display("FAIL bp_release got=%b exp=0", rsp_valid); else passed++;
      model(1'b0, 3'b010, 32'h10, 32'h0, mrd, mer, kn);
      txn(1'b0, 3'b010, 32'h10, 32'h0, 0, rd, er, lat);
      total++; if (rd !== 32'hDEAD_80EF) $display("FAIL bp_no_store got=%h exp=dead80ef", rd); else passed++;
   endtask

   task automatic test_errors;
      logic [31:0] rd, mrd; logic er, mer; bit kn; int lat;
      txn(1'b0, 3'b010, BASE + 32'(4 * DEPTH), 32'h0, 0, rd, er, lat);
      total++; if (er !== 1'b1 || rd !== 32'h0) $display("FAIL oor_lw got=%h/%b exp=0/1", rd, er); else passed++;
      txn(1'b1, 3'b100, 32'h10, 32'hFFFF_FFFF, 0, rd, er, lat);
      total++; if (er !== 1'b1) $display("FAIL store_lbu_code_err got=%b exp=1", er); else passed++;
      txn(1'b0, 3'b011, 32'h10, 32'h0, 0, rd, er, lat);
      total++; if (er !== 1'b1 || rd !== 32'h0) $display("FAIL f3_011_err got=%h/%b exp=0/1", rd, er); else passed++;
      model(1'b1, 3'b010, 32'h12, 32'hCAFE_F00D, mrd, mer, kn);
      txn(1'b1, 3'b010, 32'h12, 32'hCAFE_F00D, 0, rd, er, lat);
`ifdef DMEM_MISALIGN_TRAP_EN
      total++; if (er !== 1'b1) $display("FAIL misaligned_sw_err got=%b exp=1", er); else passed++;
      txn(1'b0, 3'b010, 32'h10, 32'h0, 0, rd, er, lat);
      total++; if (rd !== 32'hDEAD_80EF) $display("FAIL misaligned_sw_nowrite got=%h exp=dead80ef", rd); else passed++;
      txn(1'b0, 3'b101, 32'h11, 32'h0, 0, rd, er, lat);
      total++; if (er !== 1'b1 || rd !== 32'h0) $display("FAIL misaligned_lhu got=%h/%b exp=0/1", rd, er); else passed++;
`else
      total++; if (er !== 1'b0) $display("FAIL misaligned_sw_err got=%b exp=0", er); else passed++;
      txn(1'b0, 3'b010, 32'h10, 32'h0, 0, rd, er, lat);
      total++; if (rd !== 32'hCAFE_F00D) $display("FAIL misaligned_sw_write got=%h exp=cafef00d", rd); else passed++;
      txn(1'b0, 3'b101, 32'h11, 32'h0, 0, rd, er, lat);
      total++; if (er !== 1'b0 || rd !== 32'h0000_F00D) $display("FAIL misaligned_lhu got=%h/%b exp=0000f00d/0", rd, er); else passed++;
`endif
   endtask

   task automatic test_reset_busy;
      logic [31:0] rd, mrd; logic er, mer; bit kn; int lat, n;
      model(1'b1, 3'b010, 32'h20, 32'h0, mrd, mer, kn);
      txn(1'b1, 3'b010, 32'h20, 32'h0, 0, rd, er, lat);
      @(negedge clk);
      n = 0;
      while (!req_ready && n < 20) begin @(negedge clk); n++; end
      req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h20; req_wdata = 32'h1234_5678;
      @(posedge clk); #1;
      req_valid = 1'b0;
      @(posedge clk); #1;
      reset = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         total++;
         if (rsp_valid !== 1'b0 || req_ready !== 1'b0)
            $display("FAIL busy_reset_c%0d got valid=%b ready=%b exp 0/0", c, rsp_valid, req_ready);
         else passed++;
      end
      reset = 1'b1;
      txn(1'b0, 3'b010, 32'h20, 32'h0, 0, rd, er, lat);
      total++;
      if (rd !== 32'h0 || er !== 1'b0) $display("FAIL busy_reset_dropped got=%h/%b exp=0/0", rd, er);
      else passed++;
   endtask

   task automatic test_random;
      logic [31:0] rd, mrd, a, d; logic er, mer, we; logic [2:0] f3; bit kn; int lat;
      for (int w = 0; w < 32; w++) begin
         d = $urandom;
         model(1'b1, 3'b010, 32'h100 + 32'(4 * w), d, mrd, mer, kn);
         txn(1'b1, 3'b010, 32'h100 + 32'(4 * w), d, 0, rd, er, lat);
      end
      for (int t = 0; t < 150; t++) begin
         we = 1'($urandom);
         f3 = 3'($urandom);
         d  = $urandom;
         if ($urandom_range(0, 9) == 0) a = BASE + 32'(4 * DEPTH) + 32'($urandom_range(0, 4000));
         else a = 32'h100 + 32'($urandom_range(0, 127));
         model(we, f3, a, d, mrd, mer, kn);
         txn(we, f3, a, d, $urandom_range(0, 2), rd, er, lat);
         total++;
         if (er !== mer) $display("FAIL rand%0d_err we=%b f3=%b addr=%h got=%b exp=%b", t, we, f3, a, er, mer);
         else passed++;
         total++;
         if (lat != WAIT + 1) $display("FAIL rand%0d_latency got=%0d exp=%0d", t, lat, WAIT + 1);
         else passed++;
         if (kn || mer || we) begin
            total++;
            if (rd !== mrd) $display("FAIL rand%0d_rdata we=%b f3=%b addr=%h got=%h exp=%h", t, we, f3, a, rd, mrd);
            else passed++;
         end
      end
   endtask

   initial begin
      test_reset();
      test_sw_lw();
      test_byte_merge();
      test_backpressure();
      test_errors();
      test_reset_busy();
      test_random();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
